// File: rtl/if_stage.sv
// Instruction fetch stage: issues one word request at a time, hands words to decode,
// absorbs one word of decode back-pressure in a single-entry buffer and squashes
// responses made stale by a branch redirect or a flush.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_d, pc_d, inst_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d, buf_inst_q, buf_inst_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              req_d, valid_d;
    logic              ack;
    logic [XLEN-1:0]   next_seq_pc;

    // A response only completes a request that is actually on the bus.
    assign ack         = imem_ack_i & imem_req_o;
    assign next_seq_pc = imem_addr_o + XLEN'(INST_BYTES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            pc_o        <= '0;
            inst_o      <= '0;
            valid_o     <= 1'b0;
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_o  <= req_d;
            imem_addr_o <= fetch_pc_d;
            pc_o        <= pc_d;
            inst_o      <= inst_d;
            valid_o     <= valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            target_q    <= target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = imem_req_o;
        fetch_pc_d = imem_addr_o;
        pc_d       = pc_o;
        inst_d     = inst_o;
        valid_d    = valid_o;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        target_d   = target_q;

        // The presented instruction leaves decode when accepted or flushed.
        if (flush_i || !stall_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            FETCH: begin
                req_d = 1'b1;
                if (branch_i) begin
                    if (ack) begin
                        fetch_pc_d = branch_target_i;
                    end else begin
                        target_d = branch_target_i;
                        state_d  = DISCARD;
                    end
                end else if (ack && !flush_i) begin
                    fetch_pc_d = next_seq_pc;
                    if (!valid_o || !stall_i) begin
                        pc_d    = imem_addr_o;
                        inst_d  = imem_rdata_i;
                        valid_d = 1'b1;
                    end else begin
                        buf_pc_d   = imem_addr_o;
                        buf_inst_d = imem_rdata_i;
                        req_d      = 1'b0;
                        state_d    = BUFFERED;
                    end
                end
            end
            BUFFERED: begin
                if (branch_i) begin
                    fetch_pc_d = branch_target_i;
                    req_d      = 1'b1;
                    state_d    = FETCH;
                end else if (flush_i) begin
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    pc_d    = buf_pc_q;
                    inst_d  = buf_inst_q;
                    valid_d = 1'b1;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // Old request must complete on the bus before the redirect is issued.
                req_d = 1'b1;
                if (branch_i) begin
                    target_d = branch_target_i;
                end
                if (ack) begin
                    fetch_pc_d = branch_i ? branch_target_i : target_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule
